// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the PC sequencer and its surrounding pipeline.
// The master drives PC state and flow-control requests; the slave returns the next PC and status.
interface pc_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] cur_pc;
    logic            run;
    logic            halt_req;
    logic            stall;
    logic            branch_take;
    logic [PC_W-1:0] branch_target;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] next_pc;
    logic            running;
    logic            stalled;
    logic            wrap;
    logic            ras_err;

    modport master (
        output cur_pc, run, halt_req, stall,
        output branch_take, branch_target,
        output jump, jump_target, call, ret,
        input  next_pc, running, stalled, wrap, ras_err
    );

    modport slave (
        input  cur_pc, run, halt_req, stall,
        input  branch_take, branch_target,
        input  jump, jump_target, call, ret,
        output next_pc, running, stalled, wrap, ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: HALT/RUN/STALL control, next-PC selection and optional return-address stack.
// The return-address stack is built only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer #(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4
) (
    input logic           clock,
    input logic           clear_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state;
    state_t          nstate;
    logic [1:0]      sync;
    logic            active;
    logic [PC_W-1:0] inc_pc;
    logic [PC_W-1:0] npc;
    logic            incr;
    logic            running_q;
    logic            stalled_q;
    logic            wrap_q;

`ifdef PC_SEQUENCER_RAS_EN
    localparam int AW  = $clog2(RAS_DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] FULL = SPW'(RAS_DEPTH);

    logic [PC_W-1:0] stack [RAS_DEPTH];
    logic [SPW-1:0]  sp;
    logic [AW-1:0]   top_idx;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            err;
    logic            err_q;

    assign empty   = (sp == '0);
    assign full    = (sp == FULL);
    assign top_idx = sp[AW-1:0] - AW'(1);
`endif

    // Release of clear_n is retimed so the FSM never sees a partial reset edge.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) sync <= 2'b00;
        else          sync <= {sync[0], 1'b1};
    end

    assign active = sync[1];
    assign inc_pc = bus.cur_pc + PC_W'(1);

    always_comb begin
        nstate = state;
        npc    = bus.cur_pc;
        incr   = 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
        push   = 1'b0;
        pop    = 1'b0;
        err    = 1'b0;
`endif
        if (state == HALT) begin
            if (bus.run) nstate = RUN;
        end else if (bus.halt_req) begin
            nstate = HALT;
        end else if (bus.stall) begin
            nstate = STALL;
        end else begin
            nstate = RUN;
            priority case (1'b1)
                bus.ret: begin
`ifdef PC_SEQUENCER_RAS_EN
                    if (!empty) begin
                        npc = stack[top_idx];
                        pop = 1'b1;
                    end else begin
                        incr = 1'b1;
                        err  = 1'b1;
                    end
`else
                    incr = 1'b1;
`endif
                end
                bus.call: begin
                    npc = bus.jump_target;
`ifdef PC_SEQUENCER_RAS_EN
                    if (!full) push = 1'b1;
                    else       err  = 1'b1;
`endif
                end
                bus.jump:        npc  = bus.jump_target;
                bus.branch_take: npc  = bus.branch_target;
                default:         incr = 1'b1;
            endcase
            if (incr) npc = inc_pc;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= HALT;
            running_q <= 1'b0;
            stalled_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else if (active) begin
            state     <= nstate;
            running_q <= (nstate != HALT);
            stalled_q <= (nstate == STALL);
            wrap_q    <= incr && (&bus.cur_pc);
        end
    end

`ifdef PC_SEQUENCER_RAS_EN
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            if (push)     sp <= sp + SPW'(1);
            else if (pop) sp <= sp - SPW'(1);
            if (err) err_q <= 1'b1;
        end
    end

    // Entries need no reset: the stack pointer alone defines validity.
    always_ff @(posedge clock) begin
        if (push) stack[sp[AW-1:0]] <= inc_pc;
    end

    assign bus.ras_err = err_q;
`else
    assign bus.ras_err = 1'b0;
`endif

    assign bus.next_pc = npc;
    assign bus.running = running_q;
    assign bus.stalled = stalled_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table plus reset/latency sequences.
// Expectations follow whether PC_SEQUENCER_RAS_EN is defined.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit R = 1'b1;
`else
    localparam bit R = 1'b0;
`endif

    localparam int Q_RUN = 1;
    localparam int Q_HLT = 2;
    localparam int Q_STL = 4;
    localparam int Q_BR  = 8;
    localparam int Q_JMP = 16;
    localparam int Q_CL  = 32;
    localparam int Q_RT  = 64;

    typedef struct {
        logic [7:0] pc;
        int         req;
        logic [7:0] bt;
        logic [7:0] jt;
        logic [7:0] npc;
        logic       rn;
        logic       st;
        logic       wr;
        logic       er;
    } vec_t;

    logic clock;
    logic clear_n;
    int   total;
    int   bad;
    vec_t tbl[$];
    vec_t sb[$];

    pc_sequencer_if #(.PC_W(8)) bus ();

    pc_sequencer #(
        .PC_W(8),
        .RAS_DEPTH(4)
    ) dut (
        .clock(clock),
        .clear_n(clear_n),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] pc, input int req,
                       input logic [7:0] bt, input logic [7:0] jt,
                       input logic [7:0] npc, input logic rn, input logic st,
                       input logic wr, input logic er);
        vec_t v;
        v.pc = pc; v.req = req; v.bt = bt; v.jt = jt;
        v.npc = npc; v.rn = rn; v.st = st; v.wr = wr; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.cur_pc        = v.pc;
        bus.run           = (v.req & Q_RUN) != 0;
        bus.halt_req      = (v.req & Q_HLT) != 0;
        bus.stall         = (v.req & Q_STL) != 0;
        bus.branch_take   = (v.req & Q_BR) != 0;
        bus.jump          = (v.req & Q_JMP) != 0;
        bus.call          = (v.req & Q_CL) != 0;
        bus.ret           = (v.req & Q_RT) != 0;
        bus.branch_target = v.bt;
        bus.jump_target   = v.jt;
    endtask

    task automatic step(input vec_t v, input string nm);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(negedge clock);
        e = sb.pop_front();
        chk({nm, ".next_pc"}, bus.next_pc, e.npc);
        @(posedge clock);
        #1;
        chk({nm, ".running"}, 8'(bus.running), 8'(e.rn));
        chk({nm, ".stalled"}, 8'(bus.stalled), 8'(e.st));
        chk({nm, ".wrap"}, 8'(bus.wrap), 8'(e.wr));
        chk({nm, ".ras_err"}, 8'(bus.ras_err), 8'(e.er));
    endtask

    // Requests asserted during reset and the sync window must be ignored.
    task automatic do_reset(input logic [7:0] pc, input string nm);
        vec_t v;
        v.pc = pc; v.req = Q_RUN | Q_JMP | Q_RT; v.bt = 8'h00; v.jt = 8'h99;
        v.npc = pc; v.rn = 1'b0; v.st = 1'b0; v.wr = 1'b0; v.er = 1'b0;
        drive(v);
        clear_n = 1'b0;
        #1;
        chk({nm, ".rst_running"}, 8'(bus.running), 8'h00);
        chk({nm, ".rst_stalled"}, 8'(bus.stalled), 8'h00);
        chk({nm, ".rst_wrap"}, 8'(bus.wrap), 8'h00);
        chk({nm, ".rst_ras_err"}, 8'(bus.ras_err), 8'h00);
        chk({nm, ".rst_next_pc"}, bus.next_pc, pc);
        repeat (2) @(posedge clock);
        #1;
        clear_n = 1'b1;
        @(posedge clock);
        #1;
        chk({nm, ".sync_edge1"}, 8'(bus.running), 8'h00);
        @(posedge clock);
        #1;
        chk({nm, ".sync_edge2"}, 8'(bus.running), 8'h00);
        @(negedge clock);
        chk({nm, ".sync_hold_pc"}, bus.next_pc, pc);
        @(posedge clock);
        #1;
        chk({nm, ".sync_edge3"}, 8'(bus.running), 8'h01);
    endtask

    initial begin
        vec_t v;
        total   = 0;
        bad     = 0;
        clear_n = 1'b0;

        // Straight-line, wrap, priority, stall.
        add(8'h10, 0, 8'h00, 8'h00, 8'h11, 1, 0, 0, 0);
        add(8'h11, 0, 8'h00, 8'h00, 8'h12, 1, 0, 0, 0);
        add(8'h12, 0, 8'h00, 8'h00, 8'h13, 1, 0, 0, 0);
        add(8'hFF, 0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0);
        add(8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0);
        add(8'h20, Q_BR | Q_JMP, 8'h80, 8'h40, 8'h40, 1, 0, 0, 0);
        add(8'h40, Q_BR, 8'h80, 8'h00, 8'h80, 1, 0, 0, 0);
        add(8'h07, Q_STL | Q_JMP, 8'h00, 8'h55, 8'h07, 1, 1, 0, 0);
        add(8'h07, Q_STL, 8'h00, 8'h00, 8'h07, 1, 1, 0, 0);
        add(8'h07, 0, 8'h00, 8'h00, 8'h08, 1, 0, 0, 0);
        // Call/return and RAS overflow/underflow.
        add(8'h05, Q_CL, 8'h00, 8'h30, 8'h30, 1, 0, 0, 0);
        add(8'h33, Q_RT, 8'h00, 8'h00, R ? 8'h06 : 8'h34, 1, 0, 0, 0);
        add(8'h01, Q_CL, 8'h00, 8'h11, 8'h11, 1, 0, 0, 0);
        add(8'h02, Q_CL, 8'h00, 8'h12, 8'h12, 1, 0, 0, 0);
        add(8'h03, Q_CL, 8'h00, 8'h13, 8'h13, 1, 0, 0, 0);
        add(8'h04, Q_CL, 8'h00, 8'h14, 8'h14, 1, 0, 0, 0);
        add(8'h05, Q_CL, 8'h00, 8'h15, 8'h15, 1, 0, 0, R);
        add(8'h90, Q_RT, 8'h00, 8'h00, R ? 8'h05 : 8'h91, 1, 0, 0, R);
        add(8'h90, Q_RT, 8'h00, 8'h00, R ? 8'h04 : 8'h91, 1, 0, 0, R);
        add(8'h90, Q_RT, 8'h00, 8'h00, R ? 8'h03 : 8'h91, 1, 0, 0, R);
        add(8'h90, Q_RT, 8'h00, 8'h00, R ? 8'h02 : 8'h91, 1, 0, 0, R);
        add(8'h90, Q_RT, 8'h00, 8'h00, 8'h91, 1, 0, 0, R);
        // Halt priority, HALT ignoring requests, RAS preserved across halt/stall.
        add(8'h60, Q_CL, 8'h00, 8'h70, 8'h70, 1, 0, 0, R);
        add(8'h70, Q_HLT | Q_STL | Q_JMP | Q_RT, 8'h00, 8'h44, 8'h70, 0, 0, 0, R);
        add(8'h70, Q_JMP | Q_CL, 8'h00, 8'h44, 8'h70, 0, 0, 0, R);
        add(8'h70, Q_RUN, 8'h00, 8'h00, 8'h70, 1, 0, 0, R);
        add(8'h75, Q_RT, 8'h00, 8'h00, R ? 8'h61 : 8'h76, 1, 0, 0, R);
        add(8'h80, Q_CL, 8'h00, 8'h88, 8'h88, 1, 0, 0, R);
        add(8'h88, Q_STL | Q_RT, 8'h00, 8'h00, 8'h88, 1, 1, 0, R);
        add(8'h88, Q_RT, 8'h00, 8'h00, R ? 8'h81 : 8'h89, 1, 0, 0, R);
        add(8'hFE, 0, 8'h00, 8'h00, 8'hFF, 1, 0, 0, R);
        add(8'hFF, Q_BR, 8'h10, 8'h00, 8'h10, 1, 0, 0, R);

        do_reset(8'h10, "init");
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while stalled with two stacked returns: stack must be lost.
        v.bt = 8'h00; v.wr = 1'b0; v.er = R;
        v.pc = 8'h10; v.req = Q_CL; v.jt = 8'h20; v.npc = 8'h20; v.rn = 1; v.st = 0;
        step(v, "pre1");
        v.pc = 8'h20; v.req = Q_CL; v.jt = 8'h30; v.npc = 8'h30;
        step(v, "pre2");
        v.pc = 8'h30; v.req = Q_STL; v.jt = 8'h00; v.npc = 8'h30; v.st = 1;
        step(v, "pre3");
        do_reset(8'h30, "mid");
        v.pc = 8'h30; v.req = Q_RT; v.npc = 8'h31; v.rn = 1; v.st = 0; v.er = R;
        step(v, "post_ret");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, PC width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 clear_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 cur_pc  input  PC_W  current value of the PC register.
REQ-006 run  input  1  start request; honoured only in HALT.
REQ-007 halt_req  input  1  stop request.
REQ-008 stall  input  1  level; hold PC this cycle.
REQ-009 branch_take  input  1  conditional branch resolved taken; target on branch_target.
REQ-010 branch_target  input  PC_W  branch destination.
REQ-011 jump  input  1  unconditional jump; target on jump_target.
REQ-012 jump_target  input  PC_W  jump and call destination.
REQ-013 call  input  1  subroutine call.
REQ-014 ret  input  1  subroutine return.
REQ-015 next_pc  output  PC_W  combinational value the PC register loads at the next edge.
REQ-016 running  output  1  registered; high in RUN or STALL.
REQ-017 stalled  output  1  registered; high in STALL.
REQ-018 wrap  output  1  registered one-cycle pulse after an increment from all-ones to zero.
REQ-019 ras_err  output  1  registered sticky overflow/underflow flag.

Function
REQ-020 SHALL implement FSM states HALT, RUN, STALL.
REQ-021 HALT: next_pc = cur_pc; run=1 -> RUN; other requests ignored.
REQ-022 RUN/STALL: halt_req=1 -> HALT, next_pc = cur_pc; halt_req has top priority.
REQ-023 RUN/STALL with halt_req=0: stall=1 -> STALL, next_pc = cur_pc; stall=0 -> RUN.
REQ-024 Not halting or stalling, priority: ret > call > jump > branch_take > increment.
REQ-025 ret: next_pc = RAS top, pop.
REQ-026 call: next_pc = jump_target, push cur_pc+1 (mod 2^PC_W).
REQ-027 jump: next_pc = jump_target.
REQ-028 branch_take: next_pc = branch_target.
REQ-029 Default: next_pc = cur_pc+1 mod 2^PC_W; from all-ones to 0, wrap pulses high the following cycle.
REQ-030 Lower-priority requests coinciding with a higher one SHALL be dropped, not queued.
REQ-031 call with RAS full: jump still taken, push discarded, ras_err set.
REQ-032 ret with RAS empty: treated as increment, no pop, ras_err set.
REQ-033 ras_err SHALL clear only on reset.
REQ-034 Stall or halt SHALL leave the RAS unchanged.

Reset
REQ-035 clear_n low SHALL asynchronously force: state HALT, running 0, stalled 0, wrap 0, ras_err 0, RAS empty.
REQ-036 While in reset, next_pc SHALL equal cur_pc.
REQ-037 Reset mid-operation SHALL discard the RAS contents.
REQ-038 Deassertion SHALL be synchronised by a two-flop chain; first state change occurs no earlier than the second edge after release.

Configuration
REQ-039 The RAS SHALL be compiled in when PC_SEQUENCER_RAS_EN is defined.
REQ-040 With PC_SEQUENCER_RAS_EN undefined:
- call behaves as jump, with no push.
- ret behaves as increment.
- ras_err is tied to 0.
- Ports are unchanged.

Verification
REQ-041 Reset with cur_pc=8'h10, run pulse, then hold cur_pc=next_pc for 3 cycles -> next_pc 8'h11, 8'h12, 8'h13; running=1.
REQ-042 cur_pc=8'hFF in RUN, no requests -> next_pc=8'h00; wrap=1 for exactly one cycle.
REQ-043 cur_pc=8'h20 with jump=1, jump_target=8'h40, branch_take=1, branch_target=8'h80 -> next_pc=8'h40.
REQ-044 Call at 8'h05 to 8'h30, then ret at 8'h33 -> next_pc 8'h30, then 8'h06. With 5 nested calls (RAS_DEPTH=4), ras_err=1.
REQ-045 stall=1 for 2 cycles at 8'h07 -> next_pc=8'h07 and stalled=1 for both cycles; RUN resumes with 8'h08.
REQ-046 clear_n low during STALL with 2 RAS entries, then run and ret -> state HALT, then increment, ras_err=1.
